stream_cipher_unit: RTL and testbench

Parametrised, symmetric XOR-plus-rotation cipher datapath. One instance encrypts or decrypts, selected per beat by `mode`.
- Generalises the fixed 8-bit, 3-key, always-valid decryptor: data width, key count, rotation amount and key-advance rate are configurable.
- Keys are programmable at run time.
- Input and output use full valid/ready backpressure.
- Sits between the byte/word stream source and sink in both the encrypt and decrypt paths.

---
 rtl/stream_cipher_unit.sv | 146 ++++++++++++++
 tb/tb_stream_cipher_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_cipher_unit.sv
// stream_cipher_unit: two-stage XOR-plus-rotation cipher datapath.
// Stage 1 latches the accepted beat together with its mode and the key that
// was selected for it. Stage 2 holds the transformed result until the sink
// takes it. The key ring is programmable, and the key index advances on a
// beat-count basis.
module stream_cipher_unit #(
  parameter int                  DW       = 8,
  parameter int                  NKEYS    = 3,
  parameter int                  ROT      = 3,
  parameter logic [NKEYS*DW-1:0] KEY_INIT = {8'h96, 8'h3C, 8'hA5},
  localparam int                 KAW      = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [2:0]     rot_freq,
  input  logic           resync,
  input  logic           key_we,
  input  logic [KAW-1:0] key_addr,
  input  logic [DW-1:0]  key_wdata,
  input  logic           in_valid,
  input  logic [DW-1:0]  in_data,
  output logic           in_ready,
  output logic           out_valid,
  output logic [DW-1:0]  out_data,
  input  logic           out_ready
);

  // Rotate left by ROT. The value is doubled so that a plain shift yields the wrap-around.
  function automatic logic [DW-1:0] rotl(input logic [DW-1:0] x);
    logic [2*DW-1:0] t;
    t = {x, x} << ROT;
    return t[2*DW-1:DW];
  endfunction

  // Rotate right by ROT.
  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] x);
    logic [2*DW-1:0] t;
    t = {x, x} >> ROT;
    return t[DW-1:0];
  endfunction

  logic [DW-1:0]  key_q [NKEYS];
  logic [KAW-1:0] idx_q, idx_d;
  logic [2:0]     cnt_q, cnt_d;

  logic           s1_valid_q;
  logic [DW-1:0]  s1_data_q;
  logic           s1_mode_q;
  logic [DW-1:0]  s1_key_q;

  logic           s2_valid_q;
  logic [DW-1:0]  s2_data_q, s2_data_d;

  logic           s2_load;
  logic           accept;
  logic [DW-1:0]  key_sel;

  // Stage 2 can take a new beat when it is empty or is being drained this cycle.
  // Stage 1 can take one when it is empty or is moving into stage 2.
  assign s2_load   = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_load;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;

  // Key ring. A write to an address beyond the ring matches no entry and is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NKEYS; i++) key_q[i] <= KEY_INIT[i*DW +: DW];
    end else if (key_we) begin
      for (int i = 0; i < NKEYS; i++)
        if (key_addr == KAW'(i)) key_q[i] <= key_wdata;
    end
  end

  // Current key: a mux over the ring, selected by the key index.
  always_comb begin
    key_sel = '0;
    for (int i = 0; i < NKEYS; i++)
      if (idx_q == KAW'(i)) key_sel = key_q[i];
  end

  // Key-advance rule. resync wins over any advance from a beat accepted in the same cycle.
  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (resync) begin
      idx_d = '0;
      cnt_d = '0;
    end else if (accept && (rot_freq != 3'd0)) begin
      if (cnt_q >= (rot_freq - 3'd1)) begin
        cnt_d = '0;
        idx_d = (idx_q == KAW'(NKEYS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  // Key index and beat counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  // Stage 1 captures data, mode and the current key, so a later key write or index move cannot affect this beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= 1'b0;
      s1_key_q   <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= in_data;
        s1_mode_q <= mode;
        s1_key_q  <= key_sel;
      end
    end
  end

  // Transform for the beat held in stage 1.
  always_comb begin
    if (s1_mode_q) s2_data_d = rotr(s1_data_q) ^ s1_key_q;
    else           s2_data_d = rotl(s1_data_q ^ s1_key_q);
  end

  // Stage 2 is the output register. Data only moves on a load, so it stays put while the sink stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_data_q <= s2_data_d;
    end
  end

endmodule

// File: tb/tb_stream_cipher_unit.sv
module tb_stream_cipher_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] rot_freq = 3'd0;
  logic       resync = 1'b0;
  logic       key_we = 1'b0;
  logic [1:0] key_addr = 2'd0;
  logic [7:0] key_wdata = 8'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;

  stream_cipher_unit dut (
    .clk(clk), .rst(rst), .mode(mode), .rot_freq(rot_freq), .resync(resync),
    .key_we(key_we), .key_addr(key_addr), .key_wdata(key_wdata),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic [7:0] cap[$];
  int         or_mode = 0;
  bit         hold_q = 1'b0;
  logic [7:0] hold_data = 8'd0;

  int m_keys[3] = '{8'hA5, 8'h3C, 8'h96};
  int m_idx = 0;
  int m_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int m_rotl(input int x);
    return (x * 8) % 256 + x / 32;
  endfunction

  function automatic int m_rotr(input int x);
    return x / 8 + (x % 8) * 32;
  endfunction

  function automatic void model_reset();
    m_keys = '{8'hA5, 8'h3C, 8'h96};
    m_idx = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_accept(input int d, input bit m, input int rf);
    int k, e;
    k = m_keys[m_idx];
    if (m) e = m_rotr(d) ^ k;
    else   e = m_rotl(d ^ k);
    sb.push_back(8'(e));
    if (rf != 0) begin
      if (m_cnt + 1 >= rf) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 3;
      end else begin
        m_cnt++;
      end
    end
  endfunction

  task automatic cycle(input bit v, input logic [7:0] d, input bit m, input logic [2:0] rf,
                       input bit rs, input bit we, input logic [1:0] wa, input logic [7:0] wd,
                       output bit acc);
    @(negedge clk);
    in_valid = v; in_data = d; mode = m; rot_freq = rf;
    resync = rs; key_we = we; key_addr = wa; key_wdata = wd;
    #1;
    acc = v && in_ready;
    if (acc) model_accept(int'(d), m, int'(rf));
    if (rs) begin m_idx = 0; m_cnt = 0; end
    if (we && wa < 2'd3) m_keys[wa] = int'(wd);
  endtask

  task automatic idle(input bit rs = 1'b0);
    bit a;
    cycle(1'b0, 8'h00, 1'b0, 3'd0, rs, 1'b0, 2'd0, 8'h00, a);
  endtask

  task automatic send(input logic [7:0] d, input bit m, input logic [2:0] rf,
                      input bit rs = 1'b0, input bit we = 1'b0,
                      input logic [1:0] wa = 2'd0, input logic [7:0] wd = 8'h00);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      cycle(1'b1, d, m, rf, rs, we, wa, wd, acc);
      tries++;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      idle();
      n++;
    end
    if (n >= 300) chk("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: drives out_ready, checks stall stability and scoreboard order.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
      #1;
      if (hold_q && rst) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(hold_data));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", int'(out_data), -1);
        end else begin
          e = sb.pop_front();
          chk("sb_data", int'(out_data), int'(e));
          cap.push_back(out_data);
        end
      end
      hold_q = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] plain[1000];
    logic [7:0] ct[$];
    logic [7:0] e4[4];
    logic [7:0] e7[7];
    logic [2:0] rf;
    logic [7:0] bi;
    bit acc;
    int nacc, nbad;

    // Reset state
    #3;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b1;

    // Latency: accepted at edge N, visible after N+1
    or_mode = 0;
    cycle(1'b1, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0, 2'd0, 8'h00, acc);
    chk("lat_accept", int'(acc), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_edge_n", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_edge_n1", int'(out_valid), 1);
    chk("lat_data", int'(out_data), 8'h2D);
    drain();

    // Encrypt sweep
    idle(1'b1);
    cap.delete();
    for (int i = 0; i < 4; i++) send(8'h00, 1'b0, 3'd1);
    drain();
    e4 = '{8'h2D, 8'hE1, 8'hB4, 8'h2D};
    chk("sweep_count", cap.size(), 4);
    for (int i = 0; i < 4 && i < cap.size(); i++) chk($sformatf("sweep%0d", i), int'(cap[i]), int'(e4[i]));

    // Decrypt
    idle(1'b1);
    cap.delete();
    send(8'h2D, 1'b1, 3'd1);
    send(8'hE1, 1'b1, 3'd1);
    send(8'hB4, 1'b1, 3'd1);
    drain();
    chk("dec_count", cap.size(), 3);
    for (int i = 0; i < cap.size(); i++) chk($sformatf("dec%0d", i), int'(cap[i]), 0);

    // Key rate 2 with resync on the 5th beat
    idle(1'b1);
    cap.delete();
    for (int i = 0; i < 4; i++) send(8'h00, 1'b0, 3'd2);
    send(8'h00, 1'b0, 3'd2, 1'b1);
    send(8'h00, 1'b0, 3'd2);
    send(8'h00, 1'b0, 3'd2);
    drain();
    e7 = '{8'h2D, 8'h2D, 8'hE1, 8'hE1, 8'hB4, 8'h2D, 8'h2D};
    chk("rate_count", cap.size(), 7);
    for (int i = 0; i < 7 && i < cap.size(); i++) chk($sformatf("rate%0d", i), int'(cap[i]), int'(e7[i]));

    // Key write collision
    idle(1'b1);
    cap.delete();
    send(8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 8'hFF);
    send(8'h00, 1'b0, 3'd0);
    drain();
    chk("kw_count", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("kw_old_key", int'(cap[0]), 8'h2D);
      chk("kw_new_key", int'(cap[1]), 8'hFF);
    end
    begin
      bit a;
      cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 8'hA5, a);
    end

    // Backpressure
    idle(1'b1);
    cap.delete();
    or_mode = 2;
    nacc = 0;
    bi = 8'h00;
    repeat (5) begin
      cycle(1'b1, bi, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 8'h00, acc);
      if (acc) begin nacc++; bi++; end
    end
    chk("bp_accepted", nacc, 2);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_out_data", int'(out_data), 8'h2D);
    or_mode = 0;
    while (bi < 8'h04) begin send(bi, 1'b0, 3'd0); bi++; end
    drain();
    e4 = '{8'h2D, 8'h25, 8'h3D, 8'h35};
    chk("bp_count", cap.size(), 4);
    for (int i = 0; i < 4 && i < cap.size(); i++) chk($sformatf("bp%0d", i), int'(cap[i]), int'(e4[i]));

    // Random round trip
    rf = 3'($urandom_range(0, 7));
    or_mode = 1;
    idle(1'b1);
    cap.delete();
    for (int i = 0; i < 1000; i++) begin
      plain[i] = 8'($urandom);
      if ($urandom_range(0, 7) == 0) idle();
      send(plain[i], 1'b0, rf);
    end
    drain();
    chk("rt_enc_count", cap.size(), 1000);
    ct = cap;
    cap.delete();
    idle(1'b1);
    for (int i = 0; i < ct.size(); i++) begin
      if ($urandom_range(0, 7) == 0) idle();
      send(ct[i], 1'b1, rf);
    end
    drain();
    chk("rt_dec_count", cap.size(), 1000);
    nbad = 0;
    for (int i = 0; i < 1000 && i < cap.size(); i++) if (cap[i] != plain[i]) nbad++;
    chk("rt_mismatches", nbad, 0);

    // Random mixed traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)), 8'($urandom), acc);
    end
    or_mode = 0;
    drain();

    // Async reset with two beats in flight
    idle(1'b1);
    or_mode = 2;
    send(8'h11, 1'b0, 3'd1);
    send(8'h22, 1'b0, 3'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst = 1'b0;
    hold_q = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    sb.delete();
    cap.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    or_mode = 0;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    send(8'h00, 1'b0, 3'd1);
    drain();
    chk("post_rst_count", cap.size(), 1);
    if (cap.size() == 1) chk("post_rst_key0", int'(cap[0]), 8'h2D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
